// File: rtl/riscmakers_dcache_refill_ctrl_if.sv
// Bus bundle of the D-cache refill controller: refill request, store-hit write,
// memory refill beat stream and the data store write port.
interface riscmakers_dcache_refill_ctrl_if #(
    parameter int IDX_W      = 8,
    parameter int CNT_W      = 2,
    parameter int BEAT_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [IDX_W-1:0]        req_index_i;

    logic                    st_valid_i;
    logic                    st_ready_o;
    logic [IDX_W-1:0]        st_index_i;
    logic [CNT_W-1:0]        st_beat_i;
    logic [BEAT_WIDTH/8-1:0] st_be_i;
    logic [BEAT_WIDTH-1:0]   st_wdata_i;

    logic                    mem_valid_i;
    logic                    mem_ready_o;
    logic [BEAT_WIDTH-1:0]   mem_data_i;
    logic                    mem_last_i;

    logic                    ds_en_o;
    logic                    ds_we_o;
    logic [LINE_WIDTH/8-1:0] ds_be_o;
    logic [IDX_W-1:0]        ds_addr_o;
    logic [LINE_WIDTH-1:0]   ds_wdata_o;

    // slave: the refill controller; master: whoever drives requests, stores and beats
    modport slave (
        input  req_valid_i, req_index_i,
        input  st_valid_i, st_index_i, st_beat_i, st_be_i, st_wdata_i,
        input  mem_valid_i, mem_data_i, mem_last_i,
        output req_ready_o, st_ready_o, mem_ready_o,
        output ds_en_o, ds_we_o, ds_be_o, ds_addr_o, ds_wdata_o
    );

    modport master (
        output req_valid_i, req_index_i,
        output st_valid_i, st_index_i, st_beat_i, st_be_i, st_wdata_i,
        output mem_valid_i, mem_data_i, mem_last_i,
        input  req_ready_o, st_ready_o, mem_ready_o,
        input  ds_en_o, ds_we_o, ds_be_o, ds_addr_o, ds_wdata_o
    );
endinterface

// File: rtl/riscmakers_dcache_refill_ctrl.sv
// D-cache data store write front end: assembles refill beats into a full line write and
// forwards byte-enabled store hits as single-beat partial writes between refills.
module riscmakers_dcache_refill_ctrl #(
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int NUM_WORDS  = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    riscmakers_dcache_refill_ctrl_if.slave       bus,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o
);
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int IDX_W      = $clog2(NUM_WORDS);
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [BEAT_WIDTH-1:0] line_buf [BEATS];

    logic                  req_fire;
    logic                  st_fire;
    logic                  mem_fire;
    logic                  last_beat;
    logic [LINE_BYTES-1:0] st_be_line;
    logic [LINE_WIDTH-1:0] line_assembled;

    // Refill wins over a simultaneous store; readies are held low while reset is asserted.
    assign bus.req_ready_o = ~rst_i & (state == IDLE);
    assign bus.st_ready_o  = ~rst_i & (state == IDLE) & ~bus.req_valid_i;
    assign bus.mem_ready_o = ~rst_i & (state == FILL);

    assign req_fire  = bus.req_valid_i & bus.req_ready_o;
    assign st_fire   = bus.st_valid_i  & bus.st_ready_o;
    assign mem_fire  = bus.mem_valid_i & bus.mem_ready_o;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign busy_o    = (state != IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        st_be_line     = LINE_BYTES'(bus.st_be_i) << (int'(bus.st_beat_i) * BEAT_BYTES);
        line_assembled = '0;
        // The final beat goes straight into the line so the write can issue the cycle after it.
        for (int i = 0; i < BEATS; i++) begin
            line_assembled[i*BEAT_WIDTH +: BEAT_WIDTH] =
                (i == BEATS - 1) ? bus.mem_data_i : line_buf[i];
        end
    end

    // NOTE: the line buffer is plain storage with no reset; every slot is rewritten before it is used.
    always_ff @(posedge clk_i) begin
        if (mem_fire) begin
            line_buf[beat_cnt] <= bus.mem_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            idx_q          <= '0;
            bus.ds_en_o    <= 1'b0;
            bus.ds_we_o    <= 1'b0;
            bus.ds_be_o    <= '0;
            bus.ds_addr_o  <= '0;
            bus.ds_wdata_o <= '0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            bus.ds_en_o <= 1'b0;
            bus.ds_we_o <= 1'b0;
            bus.ds_be_o <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        idx_q    <= bus.req_index_i;
                        beat_cnt <= '0;
                        state    <= FILL;
                    end else if (st_fire) begin
                        bus.ds_en_o    <= 1'b1;
                        bus.ds_we_o    <= 1'b1;
                        bus.ds_be_o    <= st_be_line;
                        bus.ds_addr_o  <= bus.st_index_i;
                        bus.ds_wdata_o <= {BEATS{bus.st_wdata_i}};
                    end
                end
                FILL: begin
                    if (mem_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            // A full line is committed even when the last marker is missing.
                            bus.ds_en_o    <= 1'b1;
                            bus.ds_we_o    <= 1'b1;
                            bus.ds_be_o    <= '1;
                            bus.ds_addr_o  <= idx_q;
                            bus.ds_wdata_o <= line_assembled;
                            done_o         <= 1'b1;
                            err_o          <= ~bus.mem_last_i;
                            state          <= WRITE;
                        end else if (bus.mem_last_i) begin
                            err_o <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscmakers_dcache_refill_ctrl.sv
// Scoreboard bench for riscmakers_dcache_refill_ctrl: directed refills, stores, aborts and reset.
module tb_riscmakers_dcache_refill_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    riscmakers_dcache_refill_ctrl_if #(
        .IDX_W(8), .CNT_W(2), .BEAT_WIDTH(32), .LINE_WIDTH(128)
    ) bus ();

    riscmakers_dcache_refill_ctrl #(
        .LINE_WIDTH(128), .BEAT_WIDTH(32), .NUM_WORDS(256)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus    (bus),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o)
    );

    typedef struct {
        logic         en;
        logic [15:0]  be;
        logic [7:0]   addr;
        logic [127:0] wdata;
        logic         done;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic en, input logic [15:0] be, input logic [7:0] addr,
                            input logic [127:0] wdata, input logic done, input logic err);
        exp_t e;
        e.en = en; e.be = be; e.addr = addr; e.wdata = wdata; e.done = done; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: any data store write or status pulse must match the oldest expected event.
    always @(negedge clk_i) begin
        if (bus.ds_en_o === 1'b1 || done_o === 1'b1 || err_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {bus.ds_en_o, done_o, err_o}, 3'b000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ds_en", bus.ds_en_o, e.en);
                check("ds_we", bus.ds_we_o, e.en);
                check("ds_be", bus.ds_be_o, e.be);
                check("done", done_o, e.done);
                check("err", err_o, e.err);
                if (e.en) begin
                    check("ds_addr", bus.ds_addr_o, e.addr);
                    check("ds_wdata", bus.ds_wdata_o, e.wdata);
                end
            end
        end
    end

    task automatic send_req(input logic [7:0] idx);
        int n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_index_i = idx;
        #1;
        while (bus.req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk_i); #2; n++;
        end
        if (bus.req_ready_o !== 1'b1) check("req_timeout", bus.req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last);
        int n = 0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = data;
        bus.mem_last_i  = last;
        #1;
        while (bus.mem_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk_i); #2; n++;
        end
        if (bus.mem_ready_o !== 1'b1) check("mem_timeout", bus.mem_ready_o, 1'b1);
        @(posedge clk_i); #1;
        bus.mem_valid_i = 1'b0;
        bus.mem_last_i  = 1'b0;
    endtask

    task automatic send_store(input logic [7:0] idx, input logic [1:0] beat,
                              input logic [3:0] be, input logic [31:0] data);
        int n = 0;
        bus.st_valid_i = 1'b1;
        bus.st_index_i = idx;
        bus.st_beat_i  = beat;
        bus.st_be_i    = be;
        bus.st_wdata_i = data;
        #1;
        while (bus.st_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk_i); #2; n++;
        end
        if (bus.st_ready_o !== 1'b1) check("st_timeout", bus.st_ready_o, 1'b1);
        @(posedge clk_i); #1;
        bus.st_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid_i = 1'b0; bus.req_index_i = '0;
        bus.st_valid_i  = 1'b0; bus.st_index_i  = '0; bus.st_beat_i = '0;
        bus.st_be_i     = '0;   bus.st_wdata_i  = '0;
        bus.mem_valid_i = 1'b0; bus.mem_data_i  = '0; bus.mem_last_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_ds_en", bus.ds_en_o, 1'b0);
        check("rst_ds_we", bus.ds_we_o, 1'b0);
        check("rst_ds_be", bus.ds_be_o, 16'h0);
        check("rst_ds_addr", bus.ds_addr_o, 8'h0);
        check("rst_ds_wdata", bus.ds_wdata_o, 128'h0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req_ready", bus.req_ready_o, 1'b0);
        check("rst_st_ready", bus.st_ready_o, 1'b0);
        check("rst_mem_ready", bus.mem_ready_o, 1'b0);
        rst_i = 1'b0;
        #1;
        check("idle_req_ready", bus.req_ready_o, 1'b1);
        check("idle_st_ready", bus.st_ready_o, 1'b1);
        check("idle_mem_ready", bus.mem_ready_o, 1'b0);
        @(posedge clk_i); #1;

        // 1: full refill, then latency of req_ready returning
        push_exp(1'b1, 16'hFFFF, 8'h12,
                 128'h44444444_33333333_22222222_11111111, 1'b1, 1'b0);
        send_req(8'h12);
        check("fill_busy", busy_o, 1'b1);
        check("fill_st_ready", bus.st_ready_o, 1'b0);
        send_beat(32'h11111111, 1'b0);
        send_beat(32'h22222222, 1'b0);
        send_beat(32'h33333333, 1'b0);
        send_beat(32'h44444444, 1'b1);
        #1;
        check("write_busy", busy_o, 1'b1);
        check("write_req_ready", bus.req_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("after_write_req_ready", bus.req_ready_o, 1'b1);

        // 2: store hit, busy stays low during its write
        push_exp(1'b1, 16'h0600, 8'h05, {4{32'hAABBCCDD}}, 1'b0, 1'b0);
        send_store(8'h05, 2'd2, 4'b0110, 32'hAABBCCDD);
        #1;
        check("store_busy", busy_o, 1'b0);

        // Back-to-back stores at the lane boundaries
        push_exp(1'b1, 16'h000F, 8'hA0, {4{32'h01234567}}, 1'b0, 1'b0);
        push_exp(1'b1, 16'h8000, 8'hFF, {4{32'h89ABCDEF}}, 1'b0, 1'b0);
        send_store(8'hA0, 2'd0, 4'b1111, 32'h01234567);
        send_store(8'hFF, 2'd3, 4'b1000, 32'h89ABCDEF);
        @(posedge clk_i); #1;

        // 3: simultaneous refill and store; store waits until after done_o
        push_exp(1'b1, 16'hFFFF, 8'h20,
                 128'hD0000004_C0000003_B0000002_A0000001, 1'b1, 1'b0);
        push_exp(1'b1, 16'h00F0, 8'h21, {4{32'h5A5A5A5A}}, 1'b0, 1'b0);
        bus.req_valid_i = 1'b1; bus.req_index_i = 8'h20;
        bus.st_valid_i  = 1'b1; bus.st_index_i  = 8'h21; bus.st_beat_i = 2'd1;
        bus.st_be_i     = 4'hF; bus.st_wdata_i  = 32'h5A5A5A5A;
        #1;
        check("prio_req_ready", bus.req_ready_o, 1'b1);
        check("prio_st_ready", bus.st_ready_o, 1'b0);
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        send_beat(32'hA0000001, 1'b0);
        send_beat(32'hB0000002, 1'b0);
        send_beat(32'hC0000003, 1'b0);
        send_beat(32'hD0000004, 1'b1);
        #1;
        check("prio_write_st_ready", bus.st_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("prio_after_st_ready", bus.st_ready_o, 1'b1);
        @(posedge clk_i); #1;
        bus.st_valid_i = 1'b0;
        @(posedge clk_i); #1;

        // 4: early mem_last aborts with err and no write
        push_exp(1'b0, 16'h0000, 8'h00, 128'h0, 1'b0, 1'b1);
        send_req(8'h40);
        send_beat(32'hDEAD0001, 1'b0);
        send_beat(32'hDEAD0002, 1'b1);
        #1;
        check("abort_req_ready", bus.req_ready_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;

        // 5: missing mem_last on the final beat: err and done together, line written
        push_exp(1'b1, 16'hFFFF, 8'h41,
                 128'h00000004_00000003_00000002_00000001, 1'b1, 1'b1);
        send_req(8'h41);
        send_beat(32'h00000001, 1'b0);
        send_beat(32'h00000002, 1'b0);
        send_beat(32'h00000003, 1'b0);
        send_beat(32'h00000004, 1'b0);
        @(posedge clk_i); #1;

        // 6: reset mid-fill discards the line; a fresh refill is clean
        send_req(8'h50);
        send_beat(32'hBAD00001, 1'b0);
        send_beat(32'hBAD00002, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_ds_en", bus.ds_en_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_done", done_o, 1'b0);
        check("midrst_err", err_o, 1'b0);
        check("midrst_mem_ready", bus.mem_ready_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        push_exp(1'b1, 16'hFFFF, 8'h33,
                 128'h87654321_0F0F0F0F_F0F0F0F0_12345678, 1'b1, 1'b0);
        send_req(8'h33);
        send_beat(32'h12345678, 1'b0);
        send_beat(32'hF0F0F0F0, 1'b0);
        send_beat(32'h0F0F0F0F, 1'b0);
        send_beat(32'h87654321, 1'b1);

        repeat (5) @(posedge clk_i);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
